dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512: number of 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-007 SHALL have port req_write, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: write data.
REQ-010 SHALL have port req_wstrb, input, 4: byte write strobes; bit i covers bits 8i+7:8i.
REQ-011 SHALL have port rsp_valid, output, 1: response available.
REQ-012 SHALL have port rsp_ready, input, 1: initiator accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32: read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err, output, 1: request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-017 SHALL, on acceptance, latch write, address, wdata and wstrb, load the latency counter with LATENCY-1, and enter WAIT; if LATENCY=1, it SHALL enter RESP directly.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and enter RESP on the edge where the counter is 0.
REQ-019 SHALL assert rsp_valid exactly LATENCY cycles after the acceptance edge.
REQ-020 SHALL compute word index = addr[31:2]; the request is an error if addr[1:0]!=0 or the index is >= DEPTH.
REQ-021 SHALL, for an error, leave memory unchanged and return rsp_err=1, rsp_rdata=0.
REQ-022 SHALL commit a valid write on the edge entering RESP; a read samples memory on that same edge.
REQ-023 SHALL return post-write data for a read issued after a completed write to the same word.
REQ-024 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid=1 and rsp_ready=0 (backpressure, unbounded).
REQ-025 SHALL return to IDLE on the rsp_valid and rsp_ready handshake edge; req_ready is 1 in the following cycle (no same-cycle bypass).
REQ-026 SHALL ignore req_valid, and all req_* inputs, outside IDLE.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 SHALL drive req_ready=1 in the first cycle after rst_n deasserts.
REQ-029 SHALL, on reset mid-transaction, abort the transaction; a pending write not yet committed SHALL NOT reach memory.
REQ-030 SHALL NOT reset memory contents.

Configuration
REQ-031 SHALL honour req_wstrb when DMEM_RESPONDER_WSTRB_EN is defined, writing only the strobed bytes; a write with wstrb=0 completes without error and changes nothing.
REQ-032 SHALL, without DMEM_RESPONDER_WSTRB_EN, ignore req_wstrb and write all 32 bits on every valid write.

Structure
REQ-033 SHALL take the FSM state encoding and the 2-bit misalign mask constant from the shared package dmem_pkg.
REQ-034 SHALL place storage in one sub-module, dmem_array: one synchronous write port with byte enables and one read port.

Verification
REQ-035 SHALL cover: reset, then write 0xDEADBEEF to 0x10 and read 0x10 -> each rsp_valid arrives 2 cycles after acceptance, read data is 0xDEADBEEF, rsp_err=0.
REQ-036 SHALL cover: read of 0x13, then read of 0x800 (DEPTH=512) -> both give rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-037 SHALL cover: with rsp_ready held 0 for 5 cycles -> rsp_valid and data stay stable and req_ready=0 throughout; req_ready=1 one cycle after the handshake.
REQ-038 SHALL cover, with WSTRB_EN: write 0x11223344 full, then 0xAABBCCDD with wstrb=0101, then read -> 0x11BB33DD.
REQ-039 SHALL cover: rst_n pulsed low during WAIT of a write to 0x20 (old value 0x0) -> outputs are 0 and a read of 0x20 returns 0x0.
REQ-040 SHALL cover: LATENCY=1 build, back-to-back requests with rsp_ready=1 -> one response every 2 cycles, each 1 cycle after its acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM encoding and address constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] MISALIGN_MASK = 2'b11;
    localparam int         CNT_W         = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with one byte-enabled synchronous write port and one read port.
module dmem_array #(
    parameter int DEPTH = 512,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wbe_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding memory responder with fixed latency and response backpressure.
// Define DMEM_RESPONDER_WSTRB_EN to honour byte write strobes; otherwise every valid write stores all 32 bits.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               enter_resp;
    logic               cur_write;
    logic [31:0]        cur_addr;
    logic [31:0]        cur_wdata;
    logic [3:0]         cur_wstrb;
    logic               cur_err;
    logic [3:0]         cur_be;
    logic               mem_we;
    logic [31:0]        mem_rdata;

    // With LATENCY=1 the response is resolved on the acceptance edge, before the latches hold the request.
    assign cur_write = (state_q == IDLE) ? req_write : write_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_wstrb = (state_q == IDLE) ? req_wstrb : wstrb_q;

    assign cur_err = (|(cur_addr[1:0] & MISALIGN_MASK)) ||
                     ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));

`ifdef DMEM_RESPONDER_WSTRB_EN
    assign cur_be = cur_wstrb;
`else
    assign cur_be = 4'hF;
    logic unused_wstrb;
    assign unused_wstrb = ^cur_wstrb;
`endif

    assign mem_we = enter_resp && cur_write && !cur_err;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Leave on the edge that counts the last cycle down to zero.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d      = '0;
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (!cur_write && !cur_err) ? mem_rdata : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata),
        .wbe_i   (cur_be),
        .raddr_i (cur_addr[AW+1:2]),
        .rdata_o (mem_rdata)
    );

    assign req_ready = (state_q == IDLE) && rst_n;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder against a transaction-level model.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 512;

`ifdef DMEM_RESPONDER_WSTRB_EN
    localparam logic [31:0] EXP_STRB  = 32'h11BB33DD;
    localparam logic [31:0] EXP_ZSTRB = 32'h11BB33DD;
`else
    localparam logic [31:0] EXP_STRB  = 32'hAABBCCDD;
    localparam logic [31:0] EXP_ZSTRB = 32'h55555555;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        l_req_valid = 1'b0, l_req_write = 1'b0, l_rsp_ready = 1'b0;
    logic [31:0] l_req_addr = '0, l_req_wdata = '0;
    logic [3:0]  l_req_wstrb = 4'hF;
    logic        l_req_ready, l_rsp_valid, l_rsp_err;
    logic [31:0] l_rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(1)) u_lat1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (l_req_valid),
        .req_ready (l_req_ready),
        .req_write (l_req_write),
        .req_addr  (l_req_addr),
        .req_wdata (l_req_wdata),
        .req_wstrb (l_req_wstrb),
        .rsp_valid (l_rsp_valid),
        .rsp_ready (l_rsp_ready),
        .rsp_rdata (l_rsp_rdata),
        .rsp_err   (l_rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one request in flight, visible LAT cycles after acceptance.
    logic [31:0] mmem [0:DEPTH-1];
    bit          m_busy = 1'b0;
    int          m_age = 0;
    logic        m_write;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_strb;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    task automatic m_resolve();
        int idx;
        idx   = int'(m_addr >> 2);
        m_err = (m_addr[1:0] != 2'b00) || (idx >= DEPTH);
        m_rdata = 32'h0;
        if (!m_err) begin
            if (m_write) begin
                for (int i = 0; i < 4; i++) begin
`ifdef DMEM_RESPONDER_WSTRB_EN
                    if (m_strb[i]) mmem[idx][8*i +: 8] = m_wdata[8*i +: 8];
`else
                    mmem[idx][8*i +: 8] = m_wdata[8*i +: 8];
`endif
                end
            end else begin
                m_rdata = mmem[idx];
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_age  = 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_write = req_write;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_strb  = req_wstrb;
                if (m_age >= LAT) m_resolve();
            end
        end else if (m_age >= LAT) begin
            if (rsp_ready) m_busy = 1'b0;
        end else begin
            m_age++;
            if (m_age >= LAT) m_resolve();
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk1("rst_req_ready", req_ready, 1'b0);
            chk1("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_rsp_rdata", rsp_rdata, 32'h0);
            chk1("rst_rsp_err", rsp_err, 1'b0);
        end else begin
            chk1("model_req_ready", req_ready, !m_busy);
            chk1("model_rsp_valid", rsp_valid, m_busy && (m_age >= LAT));
            if (m_busy && (m_age >= LAT)) begin
                chk("model_rsp_rdata", rsp_rdata, m_rdata);
                chk1("model_rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int t;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk1("req_ready_timeout", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk1("rsp_valid_timeout", rsp_valid, 1'b1);
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk1("bp_rsp_valid", rsp_valid, 1'b1);
            chk1("bp_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk1("ready_after_hs", req_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        repeat (3) @(posedge clk);
        #1;
        chk1("reset_req_ready", req_ready, 1'b0);
        chk1("reset_rsp_valid", rsp_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("ready_first_cycle", req_ready, 1'b1);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        chk("wr10_latency", 32'(lat), 32'd2);
        chk1("wr10_err", er, 1'b0);
        chk("wr10_rdata", rd, 32'h0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("rd10_latency", 32'(lat), 32'd2);
        chk("rd10_rdata", rd, 32'hDEADBEEF);
        chk1("rd10_err", er, 1'b0);

        do_req(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat);
        chk1("rd13_err", er, 1'b1);
        chk("rd13_rdata", rd, 32'h0);
        do_req(1'b0, 32'h800, 32'h0, 4'h0, 0, rd, er, lat);
        chk1("rd800_err", er, 1'b1);
        chk("rd800_rdata", rd, 32'h0);
        do_req(1'b1, 32'h800, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
        chk1("wr800_err", er, 1'b1);
        do_req(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
        chk1("wr12_err", er, 1'b1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        chk("rd10_unchanged_bp", rd, 32'hDEADBEEF);

        do_req(1'b1, 32'h14, 32'h11223344, 4'hF, 0, rd, er, lat);
        do_req(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
        do_req(1'b0, 32'h14, 32'h0, 4'h0, 0, rd, er, lat);
        chk("rd14_strobed", rd, EXP_STRB);
        do_req(1'b1, 32'h14, 32'h55555555, 4'b0000, 0, rd, er, lat);
        chk1("wr14_zero_strb_err", er, 1'b0);
        do_req(1'b0, 32'h14, 32'h0, 4'h0, 0, rd, er, lat);
        chk("rd14_zero_strb", rd, EXP_ZSTRB);

        do_req(1'b1, 32'h7FC, 32'h0BADF00D, 4'hF, 0, rd, er, lat);
        chk1("wr7fc_err", er, 1'b0);
        do_req(1'b0, 32'h7FC, 32'h0, 4'h0, 0, rd, er, lat);
        chk("rd7fc_rdata", rd, 32'h0BADF00D);

        do_req(1'b1, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h12345678; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("abort_rsp_valid", rsp_valid, 1'b0);
        chk1("abort_req_ready", req_ready, 1'b0);
        chk("abort_rsp_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("rd20_after_abort", rd, 32'h0);

        @(posedge clk); #1;
        chk1("lat1_idle_ready", l_req_ready, 1'b1);
        l_req_valid = 1'b1; l_req_write = 1'b1; l_rsp_ready = 1'b1;
        l_req_addr = 32'h0; l_req_wdata = 32'hA0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk1("lat1_rsp_valid", l_rsp_valid, (k % 2) == 1);
            chk1("lat1_req_ready", l_req_ready, (k % 2) == 0);
            if ((k % 2) == 1) begin
                chk("lat1_wr_rdata", l_rsp_rdata, 32'h0);
                chk1("lat1_wr_err", l_rsp_err, 1'b0);
            end
            l_req_addr  = 32'(4 * k);
            l_req_wdata = 32'hA0 + 32'(k);
        end
        l_req_write = 1'b0;
        l_req_addr  = 32'h8;
        @(posedge clk); #1;
        l_req_valid = 1'b0;
        chk1("lat1_rd_valid", l_rsp_valid, 1'b1);
        chk("lat1_rd_rdata", l_rsp_rdata, 32'hA2);
        @(posedge clk); #1;
        chk1("lat1_rd_done", l_rsp_valid, 1'b0);
        l_rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
